// File: rtl/w_updown_counter.sv
// w_updown_counter: parametrised up/down counter with a programmable modulus,
// 74HC161-style CEP/CET count enables, a synchronous parallel load and a
// cascadable combinational terminal count (TC).
// Optional feature macro: W_UPDOWN_COUNTER_SYNC_CLR_EN adds SR_N, an
// active-low synchronous clear that takes priority over load and count.
module w_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             CP,
  input  logic             MR_N,
  input  logic             CEP,
  input  logic             CET,
  input  logic             PE_N,
  input  logic             U_D,
`ifdef W_UPDOWN_COUNTER_SYNC_CLR_EN
  input  logic             SR_N,
`endif
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC
);

  // One extra bit so MODULUS == 2**WIDTH is representable for comparisons.
  localparam logic [WIDTH:0]   MOD_X  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   LAST_X = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] LAST   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   q_x;
  logic             clr;

  assign q_x = {1'b0, q_q};

`ifdef W_UPDOWN_COUNTER_SYNC_CLR_EN
  assign clr = ~SR_N;
`else
  assign clr = 1'b0;
`endif

  // Next-state: clear > load > count > hold. Out-of-range values fold back
  // into the legal range on the first count step in either direction.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (!PE_N) begin
      q_d = D;
    end else if (CEP && CET) begin
      if (U_D) q_d = (q_x >= LAST_X) ? '0 : q_q + ONE;
      else     q_d = (q_q == '0 || q_x >= MOD_X) ? LAST : q_q - ONE;
    end
  end

  // Count register with asynchronous active-low master reset.
  always_ff @(posedge CP or negedge MR_N) begin
    if (!MR_N) q_q <= '0;
    else       q_q <= q_d;
  end

  assign Q  = q_q;
  // Terminal count is combinational so TC ripples through a CET chain.
  assign TC = CET & (U_D ? (q_x == LAST_X) : (q_q == '0));

endmodule

// File: tb/tb_w_updown_counter.sv
module tb_w_updown_counter;

  logic cp = 1'b0;
  always #5 cp = ~cp;

  logic mr_n;
`ifdef W_UPDOWN_COUNTER_SYNC_CLR_EN
  logic sr_n;
`endif

  // main decade counter
  logic a_cep, a_cet, a_pe_n, a_ud;
  logic [3:0] a_d, a_q;
  logic a_tc;
  // cascade pair
  logic c_cep, c_cet0, c_pe_n, c_ud;
  logic [3:0] c_d, c_q0, c_q1;
  logic c_tc0, c_tc1;
  // modulus-16 counter
  logic b_cep, b_cet, b_pe_n, b_ud;
  logic [3:0] b_d, b_q;
  logic b_tc;
  // WIDTH=1 toggle
  logic t_cep, t_cet, t_pe_n, t_ud;
  logic [0:0] t_d, t_q;
  logic t_tc;

  int checks = 0;
  int errors = 0;

  w_updown_counter #(.WIDTH(4), .MODULUS(10)) u10 (
    .CP(cp), .MR_N(mr_n), .CEP(a_cep), .CET(a_cet), .PE_N(a_pe_n), .U_D(a_ud),
`ifdef W_UPDOWN_COUNTER_SYNC_CLR_EN
    .SR_N(1'b1),
`endif
    .D(a_d), .Q(a_q), .TC(a_tc));

  w_updown_counter #(.WIDTH(4), .MODULUS(10)) c0 (
    .CP(cp), .MR_N(mr_n), .CEP(c_cep), .CET(c_cet0), .PE_N(c_pe_n), .U_D(c_ud),
`ifdef W_UPDOWN_COUNTER_SYNC_CLR_EN
    .SR_N(1'b1),
`endif
    .D(c_d), .Q(c_q0), .TC(c_tc0));

  w_updown_counter #(.WIDTH(4), .MODULUS(10)) c1 (
    .CP(cp), .MR_N(mr_n), .CEP(c_cep), .CET(c_tc0), .PE_N(c_pe_n), .U_D(c_ud),
`ifdef W_UPDOWN_COUNTER_SYNC_CLR_EN
    .SR_N(1'b1),
`endif
    .D(c_d), .Q(c_q1), .TC(c_tc1));

  w_updown_counter #(.WIDTH(4), .MODULUS(16)) u16 (
    .CP(cp), .MR_N(mr_n), .CEP(b_cep), .CET(b_cet), .PE_N(b_pe_n), .U_D(b_ud),
`ifdef W_UPDOWN_COUNTER_SYNC_CLR_EN
    .SR_N(sr_n),
`endif
    .D(b_d), .Q(b_q), .TC(b_tc));

  w_updown_counter #(.WIDTH(1), .MODULUS(2)) u1 (
    .CP(cp), .MR_N(mr_n), .CEP(t_cep), .CET(t_cet), .PE_N(t_pe_n), .U_D(t_ud),
`ifdef W_UPDOWN_COUNTER_SYNC_CLR_EN
    .SR_N(1'b1),
`endif
    .D(t_d), .Q(t_q), .TC(t_tc));

  typedef struct {
    logic       pe_n, cep, cet, ud;
    logic [3:0] d;
    logic [3:0] q;
    logic       tc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic pe_n, logic cep, logic cet, logic ud,
                              logic [3:0] d, logic [3:0] q, logic tc);
    vec_t v;
    v.pe_n = pe_n; v.cep = cep; v.cet = cet; v.ud = ud;
    v.d = d; v.q = q; v.tc = tc;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic edge_wait();
    @(posedge cp);
    #1;
  endtask

  initial begin
    // ---- stimulus table for the decade counter (one row per edge)
    tbl.push_back(mk(0, 1, 1, 1, 4'd0, 4'd0, 0));          // load 0
    for (int i = 1; i <= 12; i++)                          // decade up
      tbl.push_back(mk(1, 1, 1, 1, 4'd0, 4'((i % 10)), ((i % 10) == 9)));
    tbl.push_back(mk(0, 1, 1, 1, 4'd9, 4'd9, 1));          // load 9
    tbl.push_back(mk(1, 1, 0, 1, 4'd0, 4'd9, 0));          // CET=0: hold, TC=0
    tbl.push_back(mk(0, 1, 1, 0, 4'd2, 4'd2, 0));          // load 2, down
    tbl.push_back(mk(1, 1, 1, 0, 4'd0, 4'd1, 0));
    tbl.push_back(mk(1, 1, 1, 0, 4'd0, 4'd0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 4'd0, 4'd9, 0));
    tbl.push_back(mk(1, 1, 1, 0, 4'd0, 4'd8, 0));
    tbl.push_back(mk(1, 1, 1, 1, 4'd0, 4'd9, 1));          // flip to up
    tbl.push_back(mk(1, 1, 1, 1, 4'd0, 4'd0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 4'd13, 4'd13, 0));        // load beats count
    tbl.push_back(mk(1, 1, 1, 1, 4'd0, 4'd0, 0));          // 13 up -> 0
    tbl.push_back(mk(0, 1, 1, 0, 4'd13, 4'd13, 0));
    tbl.push_back(mk(1, 1, 1, 0, 4'd0, 4'd9, 0));          // 13 down -> 9
    tbl.push_back(mk(1, 0, 1, 0, 4'd0, 4'd9, 0));          // CEP=0 hold
    tbl.push_back(mk(1, 0, 1, 1, 4'd0, 4'd9, 1));          // TC ignores CEP
    tbl.push_back(mk(0, 0, 0, 1, 4'd15, 4'd15, 0));        // load w/o enables
    tbl.push_back(mk(1, 1, 1, 0, 4'd0, 4'd9, 0));          // 15 down -> 9
    tbl.push_back(mk(0, 1, 1, 1, 4'd5, 4'd5, 0));
    tbl.push_back(mk(1, 1, 0, 0, 4'd0, 4'd5, 0));          // CET=0 hold

    // ---- initial drive, reset asserted
    mr_n = 0;
`ifdef W_UPDOWN_COUNTER_SYNC_CLR_EN
    sr_n = 1;
`endif
    a_cep = 0; a_cet = 1; a_pe_n = 1; a_ud = 0; a_d = '0;
    c_cep = 0; c_cet0 = 0; c_pe_n = 1; c_ud = 1; c_d = '0;
    b_cep = 0; b_cet = 0; b_pe_n = 1; b_ud = 1; b_d = '0;
    t_cep = 0; t_cet = 0; t_pe_n = 1; t_ud = 1; t_d = '0;
    #1;
    chk("reset_q", a_q, 0);
    chk("reset_tc_down", a_tc, 1);
    @(negedge cp);
    mr_n = 1;

    // ---- async reset between edges
    @(negedge cp);
    a_pe_n = 0; a_d = 4'd7;
    edge_wait();
    chk("load7_q", a_q, 7);
    #2 mr_n = 0;                    // mid high phase, no edge
    #1;
    chk("async_clr_q", a_q, 0);
    chk("async_clr_tc", a_tc, 1);
    edge_wait();                    // load still requested while in reset
    chk("reset_hold_q", a_q, 0);
    @(negedge cp);
    mr_n = 1; a_pe_n = 1; a_cep = 1; a_cet = 1; a_ud = 1;
    edge_wait();
    chk("first_count_q", a_q, 1);

    // ---- table-driven vectors
    foreach (tbl[i]) begin
      @(negedge cp);
      a_pe_n = tbl[i].pe_n; a_cep = tbl[i].cep; a_cet = tbl[i].cet;
      a_ud = tbl[i].ud; a_d = tbl[i].d;
      edge_wait();
      chk($sformatf("vec%0d_q", i), a_q, tbl[i].q);
      chk($sformatf("vec%0d_tc", i), a_tc, tbl[i].tc);
    end

    // ---- cascade: two decades, 100 up edges from 00
    @(negedge cp);
    mr_n = 0;
    #1 mr_n = 1;
    c_cep = 1; c_cet0 = 1; c_pe_n = 1; c_ud = 1;
    #1;
    chk("casc_start", {28'd0, c_q1, c_q0}, 0);
    for (int e = 1; e <= 100; e++) begin
      edge_wait();
      chk($sformatf("casc%0d_lo", e), c_q0, (e % 100) % 10);
      chk($sformatf("casc%0d_hi", e), c_q1, (e % 100) / 10);
      chk($sformatf("casc%0d_tc", e), c_tc1, ((e % 100) == 99) ? 1 : 0);
    end
    @(negedge cp);
    c_cep = 0;

    // ---- WIDTH=1 toggle flip-flop
    t_cep = 1; t_cet = 1; t_ud = 1;
    edge_wait(); chk("tog1_q", t_q, 1); chk("tog1_tc", t_tc, 1);
    edge_wait(); chk("tog2_q", t_q, 0); chk("tog2_tc", t_tc, 0);
    edge_wait(); chk("tog3_q", t_q, 1);
    @(negedge cp); t_cep = 0;
    edge_wait(); chk("tog_hold_q", t_q, 1);
    @(negedge cp); t_ud = 0; t_cep = 1;
    #1 chk("tog_down_tc_pre", t_tc, 0);
    edge_wait(); chk("tog_down_q", t_q, 0); chk("tog_down_tc", t_tc, 1);

    // ---- modulus 16: binary wrap, then clear-vs-load on the same edge
    @(negedge cp);
    b_pe_n = 0; b_d = 4'd15; b_cet = 1; b_ud = 1;
    edge_wait(); chk("m16_load15_tc", b_tc, 1);
    @(negedge cp); b_pe_n = 1; b_cep = 1;
    edge_wait(); chk("m16_wrap_q", b_q, 0);
    @(negedge cp); b_ud = 0;
    edge_wait(); chk("m16_down_wrap_q", b_q, 15);
    @(negedge cp); b_cep = 0; b_pe_n = 0; b_d = 4'd5;
    edge_wait(); chk("m16_load5_q", b_q, 5);
    @(negedge cp);
    b_d = 4'd3;
`ifdef W_UPDOWN_COUNTER_SYNC_CLR_EN
    sr_n = 0;
    edge_wait(); chk("sync_clr_q", b_q, 0);
    @(negedge cp); sr_n = 1;
`else
    edge_wait(); chk("no_clr_load_q", b_q, 3);
`endif
    b_pe_n = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
